// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared calculator definitions. Holds the keypad position to
//                key-value map (same 4-bit encoding the display path
//                consumes), the named operator codes, the keypad scanner
//                state type and a row priority helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Operator / control key codes, shared with the display and ALU logic.
    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_CLR = 4'hE;
    localparam logic [3:0] KEY_EQ  = 4'hF;

    // Key value indexed by {row, col}. Row 3 carries '*' (clear) in column 0
    // and '#' (equals) in column 2.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, KEY_ADD,
        4'h4, 4'h5, 4'h6, KEY_SUB,
        4'h7, 4'h8, 4'h9, KEY_MUL,
        KEY_CLR, 4'h0, KEY_EQ, KEY_DIV
    };

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } kp_state_t;

    // Index of the lowest active-low row; only meaningful when some row is low.
    function automatic logic [1:0] first_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd3;
        if (!rows[2]) idx = 2'd2;
        if (!rows[1]) idx = 2'd1;
        if (!rows[0]) idx = 2'd0;
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a bus of independent asynchronous
//                bits. Resets to all ones (idle level of pulled-up lines).
//  Ports       : clk  - destination clock
//                rst  - synchronous active-high reset
//                i_d  - asynchronous input bus
//                o_q  - synchronized output bus
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 matrix keypad scanner. Drives one column low at a time,
//                senses the synchronized rows, debounces press and release,
//                and reports the decoded key with a one-cycle strobe.
//  Ports       : clk       - system clock
//                reset     - synchronous active-high reset
//                row_in    - keypad rows, active-low, asynchronous
//                col_out   - column drive, active-low one-hot
//                key_code  - value of the last accepted key
//                key_valid - one-cycle strobe on press acceptance
//                key_held  - high from press acceptance to release acceptance
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_DIV - 1);
    // Accept when this cycle's count would reach DEBOUNCE_CYCLES.
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    w_rs;

    kp_state_t     r_state,     w_state_nxt;
    logic [1:0]    r_col,       w_col_nxt;
    logic [1:0]    r_row,       w_row_nxt;
    logic [TW-1:0] r_timer,     w_timer_nxt;
    logic [DW-1:0] r_db_cnt,    w_db_cnt_nxt;
    logic [3:0]    r_key_code,  w_key_code_nxt;
    logic          r_key_valid, w_key_valid_nxt;
    logic          r_key_held,  w_key_held_nxt;
    logic          w_row_high;

    sync_2ff #(
        .WIDTH (4)
    ) u_row_sync (
        .clk (clk),
        .rst (reset),
        .i_d (row_in),
        .o_q (w_rs)
    );

    // Level of the latched row while its column stays frozen.
    assign w_row_high = w_rs[r_row];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SCAN;
            r_col       <= 2'd0;
            r_row       <= 2'd0;
            r_timer     <= '0;
            r_db_cnt    <= '0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_col       <= w_col_nxt;
            r_row       <= w_row_nxt;
            r_timer     <= w_timer_nxt;
            r_db_cnt    <= w_db_cnt_nxt;
            r_key_code  <= w_key_code_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_held  <= w_key_held_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_col_nxt       = r_col;
        w_row_nxt       = r_row;
        w_timer_nxt     = r_timer;
        w_db_cnt_nxt    = r_db_cnt;
        w_key_code_nxt  = r_key_code;
        w_key_valid_nxt = 1'b0;
        w_key_held_nxt  = r_key_held;

        case (r_state)
            SCAN: begin
                // Rows are only trusted at the end of the column slot, after
                // settling and synchronizer latency.
                if (r_timer == TIMER_LAST) begin
                    if (w_rs != 4'b1111) begin
                        w_row_nxt    = first_low_row(w_rs);
                        w_db_cnt_nxt = '0;
                        w_state_nxt  = PRESS_DB;
                    end else begin
                        w_col_nxt   = r_col + 2'd1;
                        w_timer_nxt = '0;
                    end
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end

            PRESS_DB: begin
                if (w_row_high) begin
                    w_timer_nxt = '0;
                    w_state_nxt = SCAN;
                end else if (r_db_cnt == DB_LAST) begin
                    w_key_code_nxt  = KEY_MAP[{r_row, r_col}];
                    w_key_valid_nxt = 1'b1;
                    w_key_held_nxt  = 1'b1;
                    w_db_cnt_nxt    = '0;
                    w_state_nxt     = HELD;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + DW'(1);
                end
            end

            HELD: begin
                if (w_row_high) begin
                    w_db_cnt_nxt = '0;
                    w_state_nxt  = RELEASE_DB;
                end
            end

            RELEASE_DB: begin
                if (!w_row_high) begin
                    w_state_nxt = HELD;
                end else if (r_db_cnt == DB_LAST) begin
                    w_key_held_nxt = 1'b0;
                    w_col_nxt      = r_col + 2'd1;
                    w_timer_nxt    = '0;
                    w_db_cnt_nxt   = '0;
                    w_state_nxt    = SCAN;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + DW'(1);
                end
            end

            default: w_state_nxt = SCAN;
        endcase
    end

    assign col_out   = ~(4'b0001 << r_col);
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
`default_nettype wire
